// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, register index
// type, the hard-wired zero register and the EX->ID dependency test.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BR2   = 2'd1,
    MWAIT = 2'd2,
    HALT  = 2'd3
  } state_e;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  // True when the EX destination feeds a source operand of the ID instruction.
  // Writes to $0 never create a dependency.
  function automatic logic reg_dep(input reg_idx_t wreg,
                                   input reg_idx_t rs,
                                   input reg_idx_t rt,
                                   input logic     uses_rt);
    return (wreg != REG_ZERO) && ((wreg == rs) || (uses_rt && (wreg == rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline datapath and the hazard
// controller. master = pipeline side, slave = controller side.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  reg_idx_t    id_rs;
  reg_idx_t    id_rt;
  logic        id_uses_rt;
  logic        id_branch;
  logic        id_redirect;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  reg_idx_t    ex_wreg;
  logic        mem_req;
  logic        mem_ready;
  logic        dbg_run;
  logic        dbg_step;

  logic        pc_stall;
  logic        ifid_stall;
  logic        idex_stall;
  logic        exmem_stall;
  logic        ifid_clear;
  logic        idex_clear;
  logic        memwb_clear;
  logic        mem_err;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_branch, id_redirect,
           ex_regwrite, ex_memtoreg, ex_wreg, mem_req, mem_ready,
           dbg_run, dbg_step,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall,
           ifid_clear, idex_clear, memwb_clear, mem_err, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_branch, id_redirect,
           ex_regwrite, ex_memtoreg, ex_wreg, mem_req, mem_ready,
           dbg_run, dbg_step,
    output pc_stall, ifid_stall, idex_stall, exmem_stall,
           ifid_clear, idex_clear, memwb_clear, mem_err, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_mem_timer.sv
// Data-memory wait timer: counts frozen cycles, flags the timeout while the
// controller is waiting, and keeps a sticky error flag until reset.
module hazard_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait_i,
  input  logic count_i,
  input  logic clear_i,
  output logic timeout_o,
  output logic mem_err_o
);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] cnt_q;
  logic       err_q;

  assign timeout_o = in_wait_i && (cnt_q >= LIMIT);
  assign mem_err_o = err_q;

  // Wait counter: cleared when the wait ends, otherwise counts frozen cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Sticky timeout error, only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timeout_o) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline. Resolves load-use,
// branch-in-ID and multi-cycle data-memory hazards. Debug single-stepping is
// built in when HAZARD_DBG_STEP_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  state_e      state_q, state_d;
  state_e      saved_q, saved_d;
  state_e      eval_state;
  state_e      rest_state;
  logic [15:0] stall_cnt_q;

  logic mfreeze, dep, lu_hit, alu_hit;
  logic in_wait, timeout, frz, dbg_halt, mem_err;
  logic pc_s, ifid_s, idex_s, exmem_s, ifid_c, idex_c, memwb_c;

  assign mfreeze = hz.mem_req & ~hz.mem_ready;
  assign dep     = reg_dep(hz.ex_wreg, hz.id_rs, hz.id_rt, hz.id_uses_rt);
  assign lu_hit  = hz.ex_memtoreg & dep;
  assign alu_hit = hz.ex_regwrite & ~hz.ex_memtoreg & hz.id_branch & dep;
  assign in_wait = (state_q == MWAIT);
  // The timeout cycle drops the access, so it is no longer a frozen cycle.
  assign frz     = mfreeze & ~timeout;

`ifdef HAZARD_DBG_STEP_EN
  logic step_q;
  logic step_edge;

  // Previous dbg_step level for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= hz.dbg_step;
    end
  end

  assign step_edge  = hz.dbg_step & ~step_q;
  assign dbg_halt   = ~hz.dbg_run & ~step_edge;
  assign rest_state = hz.dbg_run ? RUN : HALT;
`else
  logic unused_dbg;
  assign unused_dbg = hz.dbg_run ^ hz.dbg_step;
  assign dbg_halt   = 1'b0;
  assign rest_state = RUN;
`endif

  hazard_mem_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .in_wait_i (in_wait),
    .count_i   (frz),
    .clear_i   (in_wait & ~frz),
    .timeout_o (timeout),
    .mem_err_o (mem_err)
  );

  // Hazard priority and next state. On the cycle a memory wait ends, the
  // rules of the state that was interrupted apply (RUN after a timeout), so
  // a hazard hidden behind the freeze is resolved on release.
  always_comb begin
    eval_state = state_q;
    if (state_q == MWAIT) begin
      eval_state = timeout ? RUN : saved_q;
    end
    state_d = state_q;
    saved_d = saved_q;
    pc_s    = 1'b0;
    ifid_s  = 1'b0;
    idex_s  = 1'b0;
    exmem_s = 1'b0;
    ifid_c  = 1'b0;
    idex_c  = 1'b0;
    memwb_c = 1'b0;
    if (frz) begin
      pc_s    = 1'b1;
      ifid_s  = 1'b1;
      idex_s  = 1'b1;
      exmem_s = 1'b1;
      memwb_c = 1'b1;
      if (!in_wait) begin
        saved_d = state_q;
        state_d = MWAIT;
      end
    end else begin
      memwb_c = timeout;
      // BR2 is never interrupted by a halt: its extra stall must complete.
      if ((eval_state != BR2) && dbg_halt) begin
        pc_s    = 1'b1;
        ifid_s  = 1'b1;
        idex_s  = 1'b1;
        exmem_s = 1'b1;
        state_d = HALT;
      end else if ((eval_state == BR2) || lu_hit || alu_hit) begin
        pc_s    = 1'b1;
        ifid_s  = 1'b1;
        idex_c  = 1'b1;
        state_d = ((eval_state != BR2) && lu_hit && hz.id_branch) ? BR2 : rest_state;
      end else begin
        ifid_c  = hz.id_redirect;
        state_d = rest_state;
      end
    end
  end

  // FSM state and the state to resume after a memory wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      saved_q <= RUN;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end

  // Saturating count of PC stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (pc_s && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign hz.pc_stall    = pc_s    & ~rst;
  assign hz.ifid_stall  = ifid_s  & ~rst;
  assign hz.idex_stall  = idex_s  & ~rst;
  assign hz.exmem_stall = exmem_s & ~rst;
  assign hz.ifid_clear  = ifid_c  & ~rst;
  assign hz.idex_clear  = idex_c  & ~rst;
  assign hz.memwb_clear = memwb_c & ~rst;
  assign hz.mem_err     = mem_err;
  assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// random stimulus, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  ctl;   // {pc, ifid, idex, exmem stall, ifid, idex, memwb clear}
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // stimulus
  logic     s_rst;
  reg_idx_t s_rs, s_rt, s_wreg;
  logic     s_uses_rt, s_branch, s_redirect, s_regwrite, s_memtoreg;
  logic     s_req, s_ready, s_run, s_step;

  // model: owed = one more branch stall outstanding, waiting = memory frozen
  bit          m_owed, m_waiting, m_err, m_prev_step;
  int unsigned m_wcnt, m_cnt;

  task automatic idle();
    s_rs = 5'd0; s_rt = 5'd0; s_wreg = 5'd0;
    s_uses_rt = 1'b0; s_branch = 1'b0; s_redirect = 1'b0;
    s_regwrite = 1'b0; s_memtoreg = 1'b0;
    s_req = 1'b0; s_ready = 1'b1; s_run = 1'b1; s_step = 1'b0;
  endtask

  task automatic drive();
    rst            = s_rst;
    hz.id_rs       = s_rs;
    hz.id_rt       = s_rt;
    hz.id_uses_rt  = s_uses_rt;
    hz.id_branch   = s_branch;
    hz.id_redirect = s_redirect;
    hz.ex_regwrite = s_regwrite;
    hz.ex_memtoreg = s_memtoreg;
    hz.ex_wreg     = s_wreg;
    hz.mem_req     = s_req;
    hz.mem_ready   = s_ready;
    hz.dbg_run     = s_run;
    hz.dbg_step    = s_step;
  endtask

  task automatic model_cycle(output exp_t e);
    bit mf, dp, lu, alu, abort, halt;
    bit p, fi, ie, em, fc, ic, mc;
    p = 0; fi = 0; ie = 0; em = 0; fc = 0; ic = 0; mc = 0;
    if (s_rst) begin
      m_owed = 0; m_waiting = 0; m_err = 0; m_prev_step = 0;
      m_wcnt = 0; m_cnt = 0;
      e = '0;
      return;
    end
    e.err = m_err;
    e.cnt = m_cnt[15:0];
    mf    = s_req && !s_ready;
    dp    = (s_wreg != 5'd0) && ((s_wreg == s_rs) || (s_uses_rt && (s_wreg == s_rt)));
    lu    = s_memtoreg && dp;
    alu   = s_regwrite && !s_memtoreg && s_branch && dp;
    abort = m_waiting && (m_wcnt >= T);
`ifdef HAZARD_DBG_STEP_EN
    halt  = !s_run && !(s_step && !m_prev_step);
`else
    halt  = 0;
`endif
    m_prev_step = s_step;
    if (mf && !abort) begin
      p = 1; fi = 1; ie = 1; em = 1; mc = 1;
      m_waiting = 1;
      m_wcnt++;
    end else begin
      if (abort) begin
        mc = 1; m_err = 1; m_owed = 0;
      end
      m_waiting = 0;
      m_wcnt = 0;
      if (!m_owed && halt) begin
        p = 1; fi = 1; ie = 1; em = 1;
      end else if (m_owed || lu || alu) begin
        p = 1; fi = 1; ic = 1;
        m_owed = !m_owed && lu && s_branch;
      end else begin
        fc = s_redirect;
      end
    end
    if (p && (m_cnt < 65535)) m_cnt++;
    e.ctl = {p, fi, ie, em, fc, ic, mc};
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    drive();
    model_cycle(e);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // monitor: outputs are presented every cycle, sampled on the falling edge
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ctl", {9'd0, hz.pc_stall, hz.ifid_stall, hz.idex_stall, hz.exmem_stall,
                    hz.ifid_clear, hz.idex_clear, hz.memwb_clear}, {9'd0, e.ctl});
        chk("mem_err", {15'd0, hz.mem_err}, {15'd0, e.err});
        chk("stall_cnt", hz.stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    int unsigned long_left;
    idle();
    s_rst = 1'b1;
    drive();
    // reset holds outputs low even with a hazard on the inputs
    s_wreg = 5'd2; s_memtoreg = 1'b1; s_rs = 5'd2;
    cycle(); cycle();
    s_rst = 1'b0;
    idle(); cycle();

    // lw $2 ; add $3,$2,$4
    s_wreg = 5'd2; s_memtoreg = 1'b1; s_rs = 5'd2; s_rt = 5'd4; s_uses_rt = 1'b1;
    cycle();
    idle(); s_rs = 5'd2; s_rt = 5'd4; cycle();
    idle(); cycle();

    // lw $5 ; beq $5,$0 then taken
    s_wreg = 5'd5; s_memtoreg = 1'b1; s_rs = 5'd5; s_uses_rt = 1'b1; s_branch = 1'b1;
    cycle();
    s_wreg = 5'd0; s_memtoreg = 1'b0; s_redirect = 1'b1;
    cycle();
    cycle();
    idle(); cycle();

    // ALU -> dependent branch, rt operand
    s_regwrite = 1'b1; s_wreg = 5'd7; s_rt = 5'd7; s_uses_rt = 1'b1; s_branch = 1'b1;
    cycle();
    idle(); cycle();

    // memory wait of 3 cycles
    s_req = 1'b1; s_ready = 1'b0;
    repeat (3) cycle();
    s_ready = 1'b1; cycle();
    idle(); cycle();

    // freeze together with load-use, hazard resolved after release
    s_req = 1'b1; s_ready = 1'b0;
    s_wreg = 5'd9; s_memtoreg = 1'b1; s_rs = 5'd9; s_branch = 1'b1;
    repeat (2) cycle();
    s_ready = 1'b1; cycle();
    s_req = 1'b0; s_wreg = 5'd0; s_memtoreg = 1'b0; cycle();
    idle(); cycle();

    // zero register never hazards
    s_wreg = 5'd0; s_memtoreg = 1'b1; s_rs = 5'd0; cycle();
    idle(); cycle();

    // timeout: never ready
    s_req = 1'b1; s_ready = 1'b0;
    repeat (T + 1) cycle();
    idle(); repeat (3) cycle();

`ifdef HAZARD_DBG_STEP_EN
    // halt, two step pulses, reset mid-halt
    s_run = 1'b0;
    repeat (2) cycle();
    s_step = 1'b1; cycle();
    s_step = 1'b0; cycle();
    s_step = 1'b1; cycle();
    s_step = 1'b0; cycle();
    cycle();
    s_rst = 1'b1; cycle();
    s_rst = 1'b0; cycle();
    s_run = 1'b1; cycle();
`endif

    // random phase
    long_left = 0;
    for (int i = 0; i < 3000; i++) begin
      s_rst      = ($urandom_range(0, 299) == 0);
      s_rs       = 5'($urandom_range(0, 3));
      s_rt       = 5'($urandom_range(0, 3));
      s_wreg     = 5'($urandom_range(0, 3));
      s_uses_rt  = 1'($urandom);
      s_branch   = 1'($urandom);
      s_redirect = 1'($urandom);
      s_regwrite = 1'($urandom);
      s_memtoreg = ($urandom_range(0, 2) == 0);
      if (long_left == 0 && $urandom_range(0, 60) == 0) long_left = T + 2;
      if (long_left > 0) begin
        long_left--;
        s_req = 1'b1; s_ready = 1'b0;
      end else begin
        s_req   = ($urandom_range(0, 3) == 0);
        s_ready = 1'($urandom);
      end
      s_run  = ($urandom_range(0, 5) != 0);
      s_step = 1'($urandom);
      cycle();
    end

    idle(); s_rst = 1'b0; cycle();
    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
